// File: rtl/autoref_scheduler.sv
// Auto-refresh scheduler: periodic refresh ticks, postponed-refresh accounting,
// request handshake toward the command arbiter and the tRFC busy window.
module autoref_scheduler #(
   parameter int CNT_W       = 28,
   parameter int MAX_PENDING = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             aref_en,
   input  logic [CNT_W-1:0] aref_interval,
   input  logic [CNT_W-1:0] trfc,
   input  logic             ref_ack,
   input  logic             clr_overflow,
   output logic             ref_req,
   output logic             ref_busy,
   output logic [3:0]       pending_cnt,
   output logic             ref_overflow
);

   typedef enum logic [1:0] {IDLE, REQ, TRFC} state_t;

   localparam logic [3:0] MAXP = 4'(MAX_PENDING);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] ivl_cnt, busy_cnt;
   logic             en_eff, tick, ack_acc, ovf_set;

   assign en_eff  = aref_en & (aref_interval != '0);
   // >= rather than == so a shrunk interval fires on the very next edge
   assign tick    = en_eff & (ivl_cnt >= aref_interval - CNT_W'(1));
   assign ack_acc = ref_ack & (state == REQ);
   assign ovf_set = tick & ~ack_acc & (pending_cnt == MAXP);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (pending_cnt != 4'd0 && en_eff) state_nxt = REQ;
         REQ: begin
            if (ack_acc)      state_nxt = TRFC;
            else if (!en_eff) state_nxt = IDLE;
         end
         // a started tRFC window always runs to completion
         TRFC: if (busy_cnt <= CNT_W'(1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= IDLE;
         ref_req  <= 1'b0;
         ref_busy <= 1'b0;
      end else begin
         state    <= state_nxt;
         ref_req  <= (state_nxt == REQ);
         ref_busy <= (state_nxt == TRFC);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         ivl_cnt <= '0;
      end else if (!en_eff || tick) begin
         ivl_cnt <= '0;
      end else begin
         ivl_cnt <= ivl_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         busy_cnt <= '0;
      end else if (ack_acc) begin
         busy_cnt <= (trfc == '0) ? CNT_W'(1) : trfc;
      end else if (state == TRFC && busy_cnt != '0) begin
         busy_cnt <= busy_cnt - CNT_W'(1);
      end
   end

   // losing enable forfeits every owed refresh, including one acked this cycle
   always_ff @(posedge clk) begin
      if (!rstn) begin
         pending_cnt <= 4'd0;
      end else if (!en_eff) begin
         pending_cnt <= 4'd0;
      end else if (tick && !ack_acc && pending_cnt != MAXP) begin
         pending_cnt <= pending_cnt + 4'd1;
      end else if (ack_acc && !tick) begin
         pending_cnt <= pending_cnt - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         ref_overflow <= 1'b0;
      end else if (ovf_set) begin
         ref_overflow <= 1'b1;
      end else if (clr_overflow) begin
         ref_overflow <= 1'b0;
      end
   end

endmodule
